// File: rtl/mio_bus_responder.sv
// Responder side of the CPU memory/IO handshake: RAM port, LED/switch/counter registers.
// Optional transaction counter at 0xF000_0008 enabled by defining MIO_PERF_CNT_EN.
module mio_bus_responder #(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned RAM_AW   = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              MIO_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              bus_err
);

    localparam int unsigned DW  = 32;
    localparam int unsigned IOW = 16;
    localparam int unsigned CW  = 4;
    localparam int unsigned WAW = 30;

    localparam logic [WAW-1:0] LED_WA  = 30'h3800_0000;
    localparam logic [WAW-1:0] SW_WA   = 30'h3C00_0000;
    localparam logic [WAW-1:0] TICK_WA = 30'h3C00_0001;
`ifdef MIO_PERF_CNT_EN
    localparam logic [WAW-1:0] PERF_WA = 30'h3C00_0002;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAM_ISSUE = 2'd1,
        ST_RAM_WAIT  = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic              wr_q, wr_d;
    logic              skip_q, skip_d;
    logic [DW-1:0]     rsp_q, rsp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0]     ram_wdata_q, ram_wdata_d;
    logic [IOW-1:0]    led_q, led_d;
    logic              err_q, err_d;
    logic [DW-1:0]     tick_q, tick_d;
`ifdef MIO_PERF_CNT_EN
    logic [DW-1:0]     perf_q, perf_d;
`endif

    logic [WAW-1:0] word_c;
    logic           ram_hit_c;
    logic           accept_c;
    logic [DW-1:0]  rd_now_c;
    logic           unused_addr_c;

    assign word_c        = addr_bus[31:2];
    assign ram_hit_c     = (addr_bus[31:RAM_AW+2] == '0);
    assign accept_c      = (state_q == ST_IDLE) && CPU_MIO;
    assign rd_now_c      = skip_q ? rsp_q : ram_rdata;
    assign unused_addr_c = ^addr_bus[1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            wr_q        <= 1'b0;
            skip_q      <= 1'b0;
            rsp_q       <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            led_q       <= '0;
            err_q       <= 1'b0;
            tick_q      <= '0;
`ifdef MIO_PERF_CNT_EN
            perf_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            wr_q        <= wr_d;
            skip_q      <= skip_d;
            rsp_q       <= rsp_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            led_q       <= led_d;
            err_q       <= err_d;
            tick_q      <= tick_d;
`ifdef MIO_PERF_CNT_EN
            perf_q      <= perf_d;
`endif
        end
    end

    // Peripheral and unmapped accesses take a single pass through RAM_WAIT so
    // every transaction completes via the same counter-driven exit into RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (CPU_MIO) state_d = ram_hit_c ? ST_RAM_ISSUE : ST_RAM_WAIT;
            ST_RAM_ISSUE: state_d = ST_RAM_WAIT;
            ST_RAM_WAIT:  if (wcnt_q == '0) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        wcnt_d      = wcnt_q;
        wr_d        = wr_q;
        skip_d      = skip_q;
        rsp_d       = rsp_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        led_d       = led_q;
        err_d       = err_q;
        tick_d      = tick_q + DW'(1);
`ifdef MIO_PERF_CNT_EN
        perf_d      = perf_q + DW'(ready_q);
`endif
        if (accept_c) begin
            wr_d   = mem_w;
            wcnt_d = '0;
            skip_d = !ram_hit_c;
            if (ram_hit_c) begin
                ram_en_d    = 1'b1;
                ram_we_d    = mem_w;
                ram_addr_d  = addr_bus[RAM_AW+1:2];
                ram_wdata_d = cpu_wdata;
            end else begin
                // Counter reads return the value before this cycle's increment.
                case (word_c)
                    LED_WA: begin
                        rsp_d = DW'(led_q);
                        if (mem_w) led_d = cpu_wdata[IOW-1:0];
                    end
                    SW_WA:   rsp_d = DW'(sw_in);
                    TICK_WA: rsp_d = tick_q;
`ifdef MIO_PERF_CNT_EN
                    PERF_WA: begin
                        rsp_d = perf_q;
                        if (mem_w) perf_d = '0;
                    end
`endif
                    default: begin
                        rsp_d = '0;
                        err_d = 1'b1;
                    end
                endcase
            end
        end
        if (state_q == ST_RAM_ISSUE) wcnt_d = CW'(RAM_WAIT);
        if (state_q == ST_RAM_WAIT) begin
            rsp_d  = rd_now_c;
            skip_d = 1'b1;
            if (wcnt_q != '0) begin
                wcnt_d = wcnt_q - CW'(1);
            end else begin
                ready_d = 1'b1;
                if (!wr_q) rdata_d = rd_now_c;
            end
        end
    end

    assign cpu_rdata = rdata_q;
    assign MIO_ready = ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign led_out   = led_q;
    assign bus_err   = err_q;

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Responder end of the CPU memory/IO handshake: accepts a request, either fetch or load/store, and decodes the address.
- Drives a synchronous RAM port or internal peripheral registers.
- Returns read data and a one-cycle MIO_ready pulse after a fixed, parameterised latency.
- Sits between the multi-cycle CPU and the on-board RAM, LEDs, switches and counter.

Parameters:
RAM_WAIT, 1, extra wait cycles after RAM issue before the response (0..15)
RAM_AW, 12, RAM word-address width; RAM occupies byte range 0 .. 4*2^RAM_AW-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
CPU_MIO  input  1  request valid (level)
mem_w  input  1  1 = write, 0 = read; sampled with CPU_MIO
addr_bus  input  32  byte address; bits [1:0] ignored
cpu_wdata  input  32  write data
cpu_rdata  output  32  read data, valid in the MIO_ready cycle and held until the next response
MIO_ready  output  1  one-cycle completion pulse
ram_en  output  1  RAM access strobe, one cycle
ram_we  output  1  RAM write enable, qualified by ram_en
ram_addr  output  RAM_AW  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid 1 cycle after ram_en
sw_in  input  16  switch inputs
led_out  output  16  LED register
bus_err  output  1  sticky unmapped-access flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; MIO_ready, ram_en, ram_we, bus_err = 0; cpu_rdata, led_out, counter = 0; ram_addr and ram_wdata = 0.
- Address map, decoded on addr_bus[31:2] latched at acceptance:
  - RAM: addr < 4*2^RAM_AW.
  - LED register: 0xE000_0000, R/W, low 16 bits; read returns zero-extended.
  - Switches: 0xF000_0000, RO, zero-extended sw_in; writes ignored.
  - Counter: 0xF000_0004, RO, 32-bit free-running +1 per clk, wraps 0xFFFF_FFFF->0.
  - Anything else: unmapped.
- FSM states: IDLE, RAM_ISSUE, RAM_WAIT, RESP.
  - IDLE: if CPU_MIO=1, latch addr, mem_w, wdata.
    - RAM hit: go to RAM_ISSUE.
    - Otherwise: perform the peripheral or unmapped access this cycle and go to RESP.
  - RAM_ISSUE: ram_en=1, ram_we=latched mem_w, ram_addr=addr[RAM_AW+1:2]. Go to RAM_WAIT with wait counter = RAM_WAIT.
  - RAM_WAIT: the response is registered from ram_rdata on the first cycle here. If counter = 0, go to RESP; else decrement the counter and stay. The first cycle in RAM_WAIT counts as the RAM latency cycle.
  - RESP: MIO_ready=1 for exactly one cycle; cpu_rdata = registered read data (writes leave cpu_rdata unchanged). Go to IDLE.
- Latency from the acceptance cycle to MIO_ready:
  - RAM: 3 + RAM_WAIT cycles.
  - Peripheral or unmapped: 2 cycles.
- New requests are accepted only in IDLE. CPU_MIO asserted during any other state is ignored. CPU_MIO still high in the IDLE cycle after RESP starts a new transaction (back-to-back).
- CPU_MIO dropping mid-transaction does not abort it; the transaction completes and pulses MIO_ready.
- Unmapped access: read returns 0x0000_0000, write is discarded, bus_err is set. bus_err is cleared only by reset. MIO_ready is still pulsed so the CPU never hangs.
- LED write updates led_out at the end of the acceptance cycle (visible the next cycle). If a counter read coincides with its increment, the pre-increment value is returned.
- Async reset mid-transaction: immediate return to IDLE. No MIO_ready or ram_en pulse is produced after reset deasserts until a new request arrives.

Optional Feature:
- Macro: MIO_PERF_CNT_EN.
- Defined:
  - 32-bit transaction counter, +1 per MIO_ready pulse, wraps.
  - Readable at 0xF000_0008; a write to 0xF000_0008 clears it to 0.
  - Reset value 0.
- Undefined:
  - No counter logic.
  - 0xF000_0008 is unmapped (reads 0, sets bus_err).

Test Plan:
- RAM_WAIT=1: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 -> one ram_en with ram_we=1 and ram_addr=4. Read gives cpu_rdata=0xDEAD_BEEF with MIO_ready 4 cycles after acceptance.
- Write 0x0001_A5A5 to 0xE000_0000, then read it back -> led_out=0xA5A5 the next cycle; read returns 0x0000_A5A5. MIO_ready 2 cycles after each acceptance.
- sw_in=0x1234, read 0xF000_0000 -> cpu_rdata=0x0000_1234. Write 0xFFFF_FFFF to 0xF000_0000 -> sw read unchanged, bus_err stays 0.
- Read 0x8000_0000 -> cpu_rdata=0, bus_err=1 and stays 1 after later valid accesses; MIO_ready still pulses once.
- CPU_MIO held high for 3 consecutive RAM reads -> exactly 3 MIO_ready pulses, each separated by one IDLE cycle. Pulling reset_n low during RAM_WAIT -> outputs return to reset values at once, no MIO_ready.
- With MIO_PERF_CNT_EN defined: 5 transactions, then read 0xF000_0008 -> 0x0000_0005 (the read itself not yet counted). Write 0xF000_0008, then read -> 0x0000_0001.
